// File: rtl/sr_pq_ext_if.sv
// sr_pq_ext_if: handshake and status bundle for the sr_pq_ext priority queue.
// The master side drives push/pop/kvi/clr_err and the slave side (the queue)
// returns the head element, occupancy and the sticky error flags.
interface sr_pq_ext_if #(
   parameter int KW    = 4,
   parameter int VW    = 4,
   parameter int DEPTH = 8
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic               push;
   logic               pop;
   logic               clr_err;
   logic [KW+VW-1:0]   kvi;
   logic [KW+VW-1:0]   kvo;
   logic               vo;
   logic [CW-1:0]      count;
   logic               full;
   logic               empty;
   logic               ovf;
   logic               udf;

   modport master (
      output push, pop, clr_err, kvi,
      input  kvo, vo, count, full, empty, ovf, udf
   );

   modport slave (
      input  push, pop, clr_err, kvi,
      output kvo, vo, count, full, empty, ovf, udf
   );
endinterface

// File: rtl/sr_pq_ext.sv
// sr_pq_ext: shift-register priority queue with per-stage valid bits,
// min/max-first ordering, push+pop replace, FIFO order among equal keys,
// occupancy count and sticky overflow/underflow flags.
// Optional macro SR_PQ_EXT_PEAK_EN adds the 'peak' high-water-mark output.
// Stage 0 of the internal arrays is the head (stage 1 externally).
module sr_pq_ext #(
   parameter int KW        = 4,
   parameter int VW        = 4,
   parameter int DEPTH     = 8,
   parameter int MAX_FIRST = 0,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   sr_pq_ext_if.slave     bus
`ifdef SR_PQ_EXT_PEAK_EN
   ,
   output logic [CW-1:0]  peak
`endif
);

   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   // Stage storage
   logic [KW-1:0]    r_key [DEPTH];
   logic [VW-1:0]    r_val [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_udf;

   // Next-state values
   logic [KW-1:0]    w_key_nxt [DEPTH];
   logic [VW-1:0]    w_val_nxt [DEPTH];
   logic [DEPTH-1:0] w_vld_nxt;
   logic [CW-1:0]    w_count_nxt;

   // Shifted (popped) view and previous-stage view of the array
   logic [KW-1:0]    w_s_key [DEPTH];
   logic [VW-1:0]    w_s_val [DEPTH];
   logic [DEPTH-1:0] w_s_vld;
   logic [KW-1:0]    w_p_key [DEPTH];
   logic [VW-1:0]    w_p_val [DEPTH];
   logic [DEPTH-1:0] w_p_vld;

   // Insertion-point decode for the plain and shifted views
   logic [DEPTH-1:0] w_nb;
   logic [DEPTH-1:0] w_first;
   logic [DEPTH-1:0] w_nbs;
   logic [DEPTH-1:0] w_sfirst;

   logic [KW-1:0]    w_kin_key;
   logic [VW-1:0]    w_kin_val;
   logic             w_full;
   logic             w_empty;
   logic             w_ins;
   logic             w_del;
   logic             w_rep;
   logic             w_ovf_set;
   logic             w_udf_set;

   // Ordering predicate: does key a leave before key b? Ties never do.
   function automatic logic f_before(input logic [KW-1:0] a, input logic [KW-1:0] b);
      if (MAX_FIRST != 0) return (a > b);
      else                return (a < b);
   endfunction

   assign w_kin_key = bus.kvi[KW+VW-1:VW];
   assign w_kin_val = bus.kvi[VW-1:0];
   assign w_full    = (r_count == C_FULL);
   assign w_empty   = (r_count == '0);

   // Operation decode: insert (incl. push+pop on empty), delete, replace
   always_comb begin
      w_ins     = 1'b0;
      w_del     = 1'b0;
      w_rep     = 1'b0;
      w_ovf_set = 1'b0;
      w_udf_set = 1'b0;
      if (bus.push && !bus.pop) begin
         w_ins     = !w_full;
         w_ovf_set = w_full;
      end else if (bus.pop && !bus.push) begin
         w_del     = !w_empty;
         w_udf_set = w_empty;
      end else if (bus.push && bus.pop) begin
         w_ins     = w_empty;
         w_rep     = !w_empty;
         w_udf_set = w_empty;
      end
   end

   // Build the shifted and previous-stage views; invalid slots read as zero
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         w_s_key[i] = r_key[i+1];
         w_s_val[i] = r_val[i+1];
         w_s_vld[i] = r_vld[i+1];
      end
      w_s_key[DEPTH-1] = '0;
      w_s_val[DEPTH-1] = '0;
      w_s_vld[DEPTH-1] = 1'b0;
      w_p_key[0] = '0;
      w_p_val[0] = '0;
      w_p_vld[0] = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         w_p_key[i] = r_key[i-1];
         w_p_val[i] = r_val[i-1];
         w_p_vld[i] = r_vld[i-1];
      end
   end

   // Per-stage "new key goes before me" and first-true (insertion point) decode
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_nb[i]  = !r_vld[i]   || f_before(w_kin_key, r_key[i]);
         w_nbs[i] = !w_s_vld[i] || f_before(w_kin_key, w_s_key[i]);
      end
      w_first[0]  = w_nb[0];
      w_sfirst[0] = w_nbs[0];
      for (int i = 1; i < DEPTH; i++) begin
         w_first[i]  = w_nb[i]  && !w_nb[i-1];
         w_sfirst[i] = w_nbs[i] && !w_nbs[i-1];
      end
   end

   // Next-state of every stage and of the occupancy count
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_key_nxt[i] = r_key[i];
         w_val_nxt[i] = r_val[i];
      end
      w_vld_nxt   = r_vld;
      w_count_nxt = r_count;
      if (w_ins) begin
         w_count_nxt = r_count + CW'(1);
         for (int i = 0; i < DEPTH; i++) begin
            if (w_first[i]) begin
               w_key_nxt[i] = w_kin_key;
               w_val_nxt[i] = w_kin_val;
               w_vld_nxt[i] = 1'b1;
            end else if (w_nb[i]) begin
               w_key_nxt[i] = w_p_key[i];
               w_val_nxt[i] = w_p_val[i];
               w_vld_nxt[i] = w_p_vld[i];
            end
         end
      end else if (w_del) begin
         w_count_nxt = r_count - CW'(1);
         for (int i = 0; i < DEPTH; i++) begin
            w_key_nxt[i] = w_s_key[i];
            w_val_nxt[i] = w_s_val[i];
            w_vld_nxt[i] = w_s_vld[i];
         end
      end else if (w_rep) begin
         // Entries that still sort ahead of kvi move up one; kvi lands at the
         // first slot of the shifted view it beats; the rest stay in place.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_sfirst[i]) begin
               w_key_nxt[i] = w_kin_key;
               w_val_nxt[i] = w_kin_val;
               w_vld_nxt[i] = 1'b1;
            end else if (!w_nbs[i]) begin
               w_key_nxt[i] = w_s_key[i];
               w_val_nxt[i] = w_s_val[i];
               w_vld_nxt[i] = w_s_vld[i];
            end
         end
      end
   end

   // Stage array and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_key[i] <= '0;
            r_val[i] <= '0;
         end
         r_vld   <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_key[i] <= w_key_nxt[i];
            r_val[i] <= w_val_nxt[i];
         end
         r_vld   <= w_vld_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= w_ovf_set || (r_ovf && !bus.clr_err);
         r_udf <= w_udf_set || (r_udf && !bus.clr_err);
      end
   end

`ifdef SR_PQ_EXT_PEAK_EN
   logic [CW-1:0] r_peak;

   // High-water mark of count; clr_err restarts it from the current count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_peak <= '0;
      end else if (bus.clr_err) begin
         r_peak <= r_count;
      end else if (w_count_nxt > r_peak) begin
         r_peak <= w_count_nxt;
      end
   end

   assign peak = r_peak;
`endif

   assign bus.kvo   = {r_key[0], r_val[0]};
   assign bus.vo    = !w_empty;
   assign bus.count = r_count;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;
   assign bus.ovf   = r_ovf;
   assign bus.udf   = r_udf;

endmodule

// File: tb/tb_sr_pq_ext.sv
// tb_sr_pq_ext: self-checking bench for sr_pq_ext (min-first and max-first
// instances, KW=4, VW=4, DEPTH=4) with a sorted-list scoreboard.
module tb_sr_pq_ext;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] q_min[$];
   logic [7:0] q_max[$];

   always #5 clk = ~clk;

   sr_pq_ext_if #(.KW(4), .VW(4), .DEPTH(4)) if_min ();
   sr_pq_ext_if #(.KW(4), .VW(4), .DEPTH(4)) if_max ();

`ifdef SR_PQ_EXT_PEAK_EN
   logic [2:0] peak_min;
   logic [2:0] peak_max;
`endif

   sr_pq_ext #(.KW(4), .VW(4), .DEPTH(4), .MAX_FIRST(0)) u_min (
      .clk  (clk),
      .rst  (rst),
      .bus  (if_min)
`ifdef SR_PQ_EXT_PEAK_EN
      ,
      .peak (peak_min)
`endif
   );

   sr_pq_ext #(.KW(4), .VW(4), .DEPTH(4), .MAX_FIRST(1)) u_max (
      .clk  (clk),
      .rst  (rst),
      .bus  (if_max)
`ifdef SR_PQ_EXT_PEAK_EN
      ,
      .peak (peak_max)
`endif
   );

   // Scoreboard insert: place kv after every entry whose key is not beaten
   task automatic mdl_ins(input bit maxf, input logic [7:0] kv);
      int pos;
      bit found;
      logic [3:0] k;
      found = 0;
      if (maxf) pos = q_max.size(); else pos = q_min.size();
      for (int i = 0; i < (maxf ? q_max.size() : q_min.size()); i++) begin
         k = maxf ? q_max[i][7:4] : q_min[i][7:4];
         if (!found && (maxf ? (kv[7:4] > k) : (kv[7:4] < k))) begin
            pos   = i;
            found = 1;
         end
      end
      if (maxf) q_max.insert(pos, kv); else q_min.insert(pos, kv);
   endtask

   // Apply one operation to the scoreboard using the queue's rules
   task automatic mdl_op(input bit maxf, input logic ps, input logic pp, input logic [7:0] kv);
      int sz;
      sz = maxf ? q_max.size() : q_min.size();
      if (ps && !pp) begin
         if (sz < 4) mdl_ins(maxf, kv);
      end else if (pp && !ps) begin
         if (sz > 0) begin
            if (maxf) void'(q_max.pop_front()); else void'(q_min.pop_front());
         end
      end else if (ps && pp) begin
         if (sz > 0) begin
            if (maxf) void'(q_max.pop_front()); else void'(q_min.pop_front());
         end
         mdl_ins(maxf, kv);
      end
   endtask

   task automatic op_min(input logic ps, input logic pp, input logic ce, input logic [7:0] kv);
      mdl_op(0, ps, pp, kv);
      if_min.push = ps; if_min.pop = pp; if_min.clr_err = ce; if_min.kvi = kv;
      @(posedge clk); #1;
      if_min.push = 0; if_min.pop = 0; if_min.clr_err = 0; if_min.kvi = '0;
   endtask

   task automatic op_max(input logic ps, input logic pp, input logic ce, input logic [7:0] kv);
      mdl_op(1, ps, pp, kv);
      if_max.push = ps; if_max.pop = pp; if_max.clr_err = ce; if_max.kvi = kv;
      @(posedge clk); #1;
      if_max.push = 0; if_max.pop = 0; if_max.clr_err = 0; if_max.kvi = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (if_min.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", if_min.count); end
      total++; if (if_min.vo !== 1'b0) begin bad++; $display("FAIL rst_vo got=%b exp=0", if_min.vo); end
      total++; if (if_min.empty !== 1'b1 || if_min.full !== 1'b0) begin bad++; $display("FAIL rst_empty_full got=%b%b exp=10", if_min.empty, if_min.full); end
      total++; if (if_min.kvo !== 8'h00) begin bad++; $display("FAIL rst_kvo got=%h exp=00", if_min.kvo); end
      total++; if (if_min.ovf !== 1'b0 || if_min.udf !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", if_min.ovf, if_min.udf); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_sorted;
      logic [7:0] exp;
      logic [7:0] pat [4];
      pat[0] = 8'h51; pat[1] = 8'h22; pat[2] = 8'hF3; pat[3] = 8'h74;
      for (int i = 0; i < 4; i++) op_min(1, 0, 0, pat[i]);
      total++; if (if_min.kvo !== 8'h22) begin bad++; $display("FAIL sort_head got=%h exp=22", if_min.kvo); end
      total++; if (if_min.count !== 3'd4 || if_min.full !== 1'b1) begin bad++; $display("FAIL sort_full count=%0d full=%b exp=4,1", if_min.count, if_min.full); end
      for (int i = 0; i < 4; i++) begin
         exp = q_min[0];
         total++; if (if_min.kvo !== exp) begin bad++; $display("FAIL sort_pop%0d got=%h exp=%h", i, if_min.kvo, exp); end
         op_min(0, 1, 0, 8'h00);
      end
      total++; if (if_min.empty !== 1'b1 || if_min.vo !== 1'b0) begin bad++; $display("FAIL sort_empty empty=%b vo=%b exp=1,0", if_min.empty, if_min.vo); end
   endtask

   task automatic test_fifo_ties;
      logic [7:0] exp;
      logic [7:0] want [4];
      want[0] = 8'h3A; want[1] = 8'h3B; want[2] = 8'h3C; want[3] = 8'hF5;
      op_min(1, 0, 0, 8'h3A);
      op_min(1, 0, 0, 8'h3B);
      op_min(1, 0, 0, 8'hF5);
      op_min(1, 0, 0, 8'h3C);
      total++; if (if_min.count !== 3'd4) begin bad++; $display("FAIL tie_count got=%0d exp=4", if_min.count); end
      for (int i = 0; i < 4; i++) begin
         exp = q_min[0];
         total++; if (if_min.kvo !== exp || exp !== want[i]) begin bad++; $display("FAIL tie_pop%0d got=%h exp=%h", i, if_min.kvo, want[i]); end
         total++; if (if_min.vo !== 1'b1) begin bad++; $display("FAIL tie_vo%0d got=%b exp=1", i, if_min.vo); end
         op_min(0, 1, 0, 8'h00);
      end
   endtask

   task automatic test_replace;
      logic [7:0] exp;
      op_min(1, 0, 0, 8'h11);
      op_min(1, 0, 0, 8'h42);
      op_min(1, 0, 0, 8'h63);
      op_min(1, 0, 0, 8'h94);
      op_min(1, 1, 0, 8'h55);
      total++; if (if_min.kvo !== 8'h42) begin bad++; $display("FAIL rep_head got=%h exp=42", if_min.kvo); end
      total++; if (if_min.count !== 3'd4 || if_min.ovf !== 1'b0) begin bad++; $display("FAIL rep_count count=%0d ovf=%b exp=4,0", if_min.count, if_min.ovf); end
      op_min(1, 0, 0, 8'h00);
      total++; if (if_min.ovf !== 1'b1 || if_min.count !== 3'd4 || if_min.kvo !== 8'h42) begin bad++; $display("FAIL ovf_set ovf=%b count=%0d kvo=%h exp=1,4,42", if_min.ovf, if_min.count, if_min.kvo); end
      op_min(0, 0, 0, 8'h00);
      total++; if (if_min.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", if_min.ovf); end
      op_min(0, 0, 1, 8'h00);
      total++; if (if_min.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", if_min.ovf); end
      op_min(1, 1, 0, 8'h07);
      total++; if (if_min.kvo !== 8'h07) begin bad++; $display("FAIL rep_front got=%h exp=07", if_min.kvo); end
      op_min(1, 1, 0, 8'hFE);
      total++; if (if_min.kvo !== 8'h55) begin bad++; $display("FAIL rep_back got=%h exp=55", if_min.kvo); end
      for (int i = 0; i < 4; i++) begin
         exp = q_min[0];
         total++; if (if_min.kvo !== exp) begin bad++; $display("FAIL rep_pop%0d got=%h exp=%h", i, if_min.kvo, exp); end
         op_min(0, 1, 0, 8'h00);
      end
      total++; if (if_min.empty !== 1'b1) begin bad++; $display("FAIL rep_empty got=%b exp=1", if_min.empty); end
   endtask

   task automatic test_underflow;
      op_min(0, 1, 0, 8'h00);
      total++; if (if_min.udf !== 1'b1 || if_min.count !== 3'd0) begin bad++; $display("FAIL udf_set udf=%b count=%0d exp=1,0", if_min.udf, if_min.count); end
      op_min(0, 0, 1, 8'h00);
      total++; if (if_min.udf !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b exp=0", if_min.udf); end
      op_min(1, 1, 0, 8'h81);
      total++; if (if_min.kvo !== 8'h81 || if_min.count !== 3'd1 || if_min.udf !== 1'b1) begin bad++; $display("FAIL pushpop_empty kvo=%h count=%0d udf=%b exp=81,1,1", if_min.kvo, if_min.count, if_min.udf); end
      op_min(0, 1, 0, 8'h00);
      op_min(0, 1, 1, 8'h00);
      total++; if (if_min.udf !== 1'b1) begin bad++; $display("FAIL udf_wins got=%b exp=1", if_min.udf); end
      op_min(0, 0, 1, 8'h00);
      total++; if (if_min.udf !== 1'b0 || if_min.count !== 3'd0) begin bad++; $display("FAIL udf_clr2 udf=%b count=%0d exp=0,0", if_min.udf, if_min.count); end
   endtask

   task automatic test_max_first;
      logic [7:0] exp;
      op_max(1, 0, 0, 8'h21);
      op_max(1, 0, 0, 8'h92);
      op_max(1, 0, 0, 8'h43);
      total++; if (if_max.kvo !== 8'h92) begin bad++; $display("FAIL max_head got=%h exp=92", if_max.kvo); end
      for (int i = 0; i < 3; i++) begin
         exp = q_max[0];
         total++; if (if_max.kvo !== exp) begin bad++; $display("FAIL max_pop%0d got=%h exp=%h", i, if_max.kvo, exp); end
         op_max(0, 1, 0, 8'h00);
      end
      total++; if (if_max.empty !== 1'b1) begin bad++; $display("FAIL max_empty got=%b exp=1", if_max.empty); end
   endtask

   task automatic test_back_to_back;
      logic ps, pp;
      logic [7:0] kv;
      int errs;
      errs = 0;
      for (int n = 0; n < 300; n++) begin
         ps = 1'($urandom_range(0, 1));
         pp = 1'($urandom_range(0, 1));
         kv = {4'($urandom_range(0, 3)), 4'(n)};
         op_min(ps, pp, 1'b0, kv);
         total++;
         if (if_min.count !== 3'(q_min.size()) || if_min.vo !== (q_min.size() != 0) ||
             (q_min.size() != 0 && if_min.kvo !== q_min[0])) begin
            bad++;
            if (errs < 5)
               $display("FAIL b2b_cycle%0d count=%0d kvo=%h exp_count=%0d exp_kvo=%h", n, if_min.count, if_min.kvo,
                        q_min.size(), (q_min.size() != 0) ? q_min[0] : 8'h00);
            errs++;
         end
      end
      while (q_min.size() != 0) op_min(0, 1, 0, 8'h00);
      op_min(0, 0, 1, 8'h00);
   endtask

   task automatic test_async_reset;
      op_min(1, 0, 0, 8'h61);
      op_min(1, 0, 0, 8'h32);
      op_min(1, 0, 0, 8'h93);
      total++; if (if_min.count !== 3'd3) begin bad++; $display("FAIL ar_pre count=%0d exp=3", if_min.count); end
      if_min.push = 1'b1; if_min.kvi = 8'h14;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      total++; if (if_min.count !== 3'd0 || if_min.vo !== 1'b0) begin bad++; $display("FAIL ar_clear count=%0d vo=%b exp=0,0", if_min.count, if_min.vo); end
      if_min.push = 1'b0; if_min.kvi = '0;
      q_min.delete();
      q_max.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (if_min.count !== 3'd0 || if_min.empty !== 1'b1) begin bad++; $display("FAIL ar_after count=%0d empty=%b exp=0,1", if_min.count, if_min.empty); end
   endtask

`ifdef SR_PQ_EXT_PEAK_EN
   task automatic test_peak;
      total++; if (peak_min !== 3'd0) begin bad++; $display("FAIL peak_rst got=%0d exp=0", peak_min); end
      op_min(1, 0, 0, 8'h11);
      op_min(1, 0, 0, 8'h22);
      op_min(1, 0, 0, 8'h33);
      op_min(0, 1, 0, 8'h00);
      op_min(0, 1, 0, 8'h00);
      total++; if (peak_min !== 3'd3 || if_min.count !== 3'd1) begin bad++; $display("FAIL peak_hold peak=%0d count=%0d exp=3,1", peak_min, if_min.count); end
      op_min(0, 0, 1, 8'h00);
      total++; if (peak_min !== 3'd1) begin bad++; $display("FAIL peak_clr got=%0d exp=1", peak_min); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      if_min.push = 0; if_min.pop = 0; if_min.clr_err = 0; if_min.kvi = '0;
      if_max.push = 0; if_max.pop = 0; if_max.clr_err = 0; if_max.kvi = '0;
      test_reset();
      test_sorted();
      test_fifo_ties();
      test_replace();
      test_underflow();
      test_max_first();
      test_back_to_back();
      test_async_reset();
`ifdef SR_PQ_EXT_PEAK_EN
      test_peak();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sr_pq_ext.md
Name: sr_pq_ext

Overview:
- Parametrised shift-register priority queue, successor to the basic sentinel-key queue.
- Each stage stores an explicit valid bit, so every key value, including all-ones, is a legal key.
- Adds:
  - selectable min- or max-first ordering;
  - a combined pop+push (replace) operation, legal even when full;
  - FIFO ordering among equal keys;
  - an occupancy count and sticky error flags.
- Used as the scheduling/sort queue in front of packet and event engines.

Parameters:
KW, 4, key width in bits (>=1)
VW, 4, value width in bits (>=1)
DEPTH, 8, number of stages (>=2)
MAX_FIRST, 0, 0 = smallest key at head; 1 = largest key at head
CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
push  input  1  insert kvi this cycle
pop  input  1  remove head this cycle
kvi  input  KW+VW  key in [KW+VW-1:VW], value in [VW-1:0]
kvo  output  KW+VW  head element (stage 1), registered
vo  output  1  head valid (= !empty)
count  output  CW  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
ovf  output  1  sticky: push while full without pop
udf  output  1  sticky: pop while empty
clr_err  input  1  synchronous clear of ovf/udf

Behaviour:
- Reset:
  - all stage valid bits = 0, stage data = 0, count = 0;
  - kvo = 0, vo = 0, empty = 1, full = 0, ovf = 0, udf = 0.
- Stage array 1..DEPTH; valid entries are always contiguous from stage 1 and sorted.
- "before(a,b)": a<b when MAX_FIRST=0, a>b when MAX_FIRST=1 (unsigned compare).
- Each stage computes new_before_me = valid & before(kvi.key, key), or !valid.
  - Equal keys never go before, so equal keys leave in arrival order.
- Operations, one result per clock, all outputs registered (zero combinational path from kvi to kvo):
  - push only, !full: stages where new_before_me is false hold; the first true stage loads kvi; later stages take the previous stage's data. count+1.
  - push only, full: queue unchanged, ovf <= 1.
  - pop only, !empty: every stage takes the next stage's data; stage DEPTH becomes invalid. count-1.
  - pop only, empty: no change, udf <= 1.
  - push+pop, !empty (replace): head removed and kvi inserted in the same cycle; count unchanged; legal when full.
    - Stage i loads kvi if it is the insertion point in the shifted view.
    - Otherwise it loads stage i+1 if i+1 sorts before kvi, else stage i.
  - push+pop, empty: behaves as push only (kvi enters stage 1), udf <= 1.
  - neither: hold.
- Latency: pushed element visible at kvo the cycle after push if it becomes the head; pop takes effect the next edge.
- clr_err: clears ovf/udf next edge; a new error in the same cycle wins (flag stays 1).
- rst asserted mid-operation: immediate clear; the in-flight op is lost.
- full/empty/vo derived from the registered count; consistent every cycle.

Optional Feature:
- Macro SR_PQ_EXT_PEAK_EN.
- Defined:
  - adds output port peak [CW-1:0], the maximum count since reset or clr_err;
  - it updates on the same edge as count and resets to 0.
  - clr_err loads peak with the current count.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Setup for all scenarios: KW=4, VW=4, DEPTH=4.
- Reset then push keys 5,2,F,7 (values 1,2,3,4), MAX_FIRST=0 -> kvo=0x22, count=4, full=1; pops yield 0x22,0x51,0x74,0xF3, then empty=1, vo=0.
- Push keys 3,3,3 with values A,B,C -> pops return 0x3A,0x3B,0x3C (FIFO among ties); key F accepted as a valid entry.
- Full queue {1,4,6,9} plus push+pop of key 5 -> head 1 removed, contents {4,5,6,9}, count stays 4, ovf=0; push-only of key 0 while full -> contents unchanged, ovf=1 until clr_err.
- Pop on empty -> udf=1, count=0; push+pop on empty with 0x81 -> kvo=0x81, count=1, udf=1.
- MAX_FIRST=1: push 2,9,4 -> kvo key 9; pops give 9,4,2.
- Assert rst asynchronously mid-burst with 3 entries -> count=0, vo=0 before the next clock edge.
- With SR_PQ_EXT_PEAK_EN, push 3 then pop 2 -> peak=3, count=1.
